// File: rtl/pc_sequencer.sv
// Instruction sequencer that turns decoded opcode classes into program-counter
// commands (hold / increment / load / delay) with a bounded wait state.
module pc_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        instr_valid,
    input  logic [2:0]  opClass,
    input  logic        zeroFlag,
    input  logic [19:0] immAddress,
    input  logic [19:0] regAddress,
    input  logic [9:0]  delayCount,
    output logic        instr_ready,
    output logic [1:0]  flagPC,
    output logic [19:0] newAddress,
    output logic [9:0]  delay,
    output logic        busy,
    output logic        halted,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [1:0] PC_HOLD  = 2'd0;
    localparam logic [1:0] PC_INC   = 2'd1;
    localparam logic [1:0] PC_LOAD  = 2'd2;
    localparam logic [1:0] PC_DELAY = 2'd3;

    state_t      r_state;
    logic [2:0]  r_opClass;
    logic [9:0]  r_waitCnt;

    state_t      w_nextState;
    logic [2:0]  w_nextOpClass;
    logic [9:0]  w_nextWaitCnt;
    logic [1:0]  w_nextFlagPC;
    logic [19:0] w_nextNewAddress;
    logic [9:0]  w_nextDelay;
    logic        w_nextError;

    // Outputs are computed for the state being entered, then registered, so
    // every registered output lines up with the state it describes.
    always_comb begin
        w_nextState      = r_state;
        w_nextOpClass    = r_opClass;
        w_nextWaitCnt    = r_waitCnt;
        w_nextFlagPC     = PC_HOLD;
        w_nextNewAddress = newAddress;
        w_nextDelay      = delay;
        w_nextError      = error;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_FETCH;
                end
            end
            S_FETCH: begin
                if (instr_valid) begin
                    w_nextState   = S_EXEC;
                    w_nextOpClass = opClass;
                    w_nextWaitCnt = delayCount;
                    case (opClass)
                        3'd0: w_nextFlagPC = PC_INC;
                        3'd1: begin
                            w_nextFlagPC     = PC_LOAD;
                            w_nextNewAddress = immAddress;
                        end
                        3'd2: begin
                            if (zeroFlag) begin
                                w_nextFlagPC     = PC_LOAD;
                                w_nextNewAddress = immAddress;
                            end else begin
                                w_nextFlagPC = PC_INC;
                            end
                        end
                        3'd3: begin
                            w_nextFlagPC     = PC_LOAD;
                            w_nextNewAddress = regAddress;
                        end
                        3'd4: begin
                            w_nextFlagPC = PC_DELAY;
                            w_nextDelay  = delayCount;
                        end
                        default: w_nextFlagPC = PC_HOLD;
                    endcase
                end
            end
            S_EXEC: begin
                case (r_opClass)
                    3'd4: begin
                        if (r_waitCnt != 10'd0) begin
                            w_nextState  = S_WAIT;
                            w_nextFlagPC = PC_DELAY;
                        end else begin
                            w_nextState = S_FETCH;
                        end
                    end
                    3'd5: w_nextState = S_HALT;
                    3'd6, 3'd7: begin
                        w_nextState = S_HALT;
                        w_nextError = 1'b1;
                    end
                    default: w_nextState = S_FETCH;
                endcase
            end
            S_WAIT: begin
                // The counter holds the number of WAIT cycles still owed, including this one.
                w_nextWaitCnt = r_waitCnt - 10'd1;
                if (r_waitCnt == 10'd1) begin
                    w_nextState = S_FETCH;
                end else begin
                    w_nextFlagPC = PC_DELAY;
                end
            end
            S_HALT: begin
                w_nextState = S_HALT;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_opClass   <= 3'd0;
            r_waitCnt   <= 10'd0;
            flagPC      <= PC_HOLD;
            newAddress  <= 20'd0;
            delay       <= 10'd0;
            instr_ready <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            error       <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_opClass   <= w_nextOpClass;
            r_waitCnt   <= w_nextWaitCnt;
            flagPC      <= w_nextFlagPC;
            newAddress  <= w_nextNewAddress;
            delay       <= w_nextDelay;
            instr_ready <= (w_nextState == S_FETCH);
            busy        <= (w_nextState == S_FETCH) || (w_nextState == S_EXEC) ||
                           (w_nextState == S_WAIT);
            halted      <= (w_nextState == S_HALT);
            error       <= w_nextError;
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning):
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching.
- instr_valid  in  1  decoded instruction fields are valid this cycle.
- opClass  in  3  0 sequential, 1 jump, 2 branch-if-zero, 3 jump-register, 4 delay, 5 halt, 6–7 illegal.
- zeroFlag  in  1  ALU zero condition for branch-if-zero.
- immAddress  in  20  jump/branch target.
- regAddress  in  20  jump-register target.
- delayCount  in  10  delay operand.
- instr_ready  out  1  sequencer accepts an instruction this cycle.
- flagPC  out  2  program counter command: 0 hold, 1 increment, 2 load newAddress, 3 delay-count.
- newAddress  out  20  load target for the program counter.
- delay  out  10  delay compare value for the program counter.
- busy  out  1  sequencer is not in IDLE or HALT.
- halted  out  1  sequencer is in HALT.
- error  out  1  sticky illegal-opcode flag.

REQ-002 The block SHALL have no parameters.

Function
REQ-003 The block SHALL implement the states IDLE, FETCH, EXEC, WAIT and HALT. All outputs SHALL be registered.
REQ-004 In IDLE, start=1 SHALL cause a transition to FETCH on the next edge. Otherwise the block SHALL remain in IDLE.
REQ-005 instr_ready SHALL be 1 only in FETCH.
REQ-006 In FETCH, instr_valid=1 SHALL capture opClass, zeroFlag, immAddress, regAddress and delayCount, then move to EXEC. instr_valid=0 SHALL keep the block in FETCH with flagPC=0.
REQ-007 flagPC SHALL be nonzero only in EXEC and WAIT. It SHALL be 0 in IDLE, FETCH and HALT.
REQ-008 In EXEC, for one cycle, the captured opClass SHALL produce the following, after which the block returns to FETCH:
- 0: flagPC=1.
- 1: flagPC=2, newAddress=immAddress.
- 2: flagPC=2 and newAddress=immAddress if zeroFlag=1; otherwise flagPC=1.
- 3: flagPC=2, newAddress=regAddress.
REQ-009 Delay (opClass 4): flagPC=3 and delay=delayCount SHALL be held for exactly delayCount+1 consecutive cycles (EXEC plus delayCount cycles in WAIT), then the block returns to FETCH. delayCount=0 SHALL yield a single EXEC cycle with no WAIT.
REQ-010 The WAIT cycle counter SHALL be 10 bits. delayCount=1023 SHALL yield 1024 cycles without wrap error.
REQ-011 Halt (opClass 5): EXEC SHALL drive flagPC=0 and then enter HALT.
REQ-012 Illegal opcode (opClass 6 or 7): EXEC SHALL drive flagPC=0, set error=1 and enter HALT.
REQ-013 HALT SHALL be left only by reset. start SHALL be ignored in HALT.
REQ-014 newAddress and delay SHALL keep their last values when not in use. They SHALL be treated as don't-care while flagPC is not 2 or 3 respectively.
REQ-015 busy SHALL be 1 in FETCH, EXEC and WAIT.
REQ-016 Each accepted instruction SHALL advance the program counter by exactly one command sequence. There SHALL be no back-to-back acceptance: at least one FETCH cycle separates consecutive EXEC cycles.

Reset
REQ-017 reset=1 SHALL, on the next edge and in any state, set: state=IDLE, flagPC=0, newAddress=0, delay=0, instr_ready=0, busy=0, halted=0, error=0, and clear the WAIT counter.
REQ-018 reset SHALL take priority over start, instr_valid and any in-progress delay.
REQ-019 The block SHALL share reset with the program counter, so that a reset mid-WAIT leaves no residual flagPC=3.

Verification
REQ-020 Reset, then start=1, then opClass=0 with instr_valid=1 -> flagPC=1 for exactly 1 cycle, 2 cycles after instr_valid, then instr_ready=1.
REQ-021 Branch opClass=2, immAddress=0x00ABC: with zeroFlag=1 -> flagPC=2 and newAddress=0x00ABC; with zeroFlag=0 -> flagPC=1.
REQ-022 Delay opClass=4 with delayCount=3 -> flagPC=3 and delay=3 for exactly 4 cycles, then FETCH; repeat with delayCount=0 -> 1 cycle.
REQ-023 Delay opClass=4 with delayCount=10, reset asserted on the 5th WAIT cycle -> next cycle flagPC=0, state=IDLE and all outputs 0.
REQ-024 opClass=7 -> error=1 and halted=1; start=1 afterwards leaves the block in HALT; reset clears error and halted.
REQ-025 opClass=3 with regAddress=0xFFFFF, followed by opClass=5 -> flagPC=2 and newAddress=0xFFFFF, then halted=1 with flagPC=0 thereafter.
